// File: rtl/adder_tree_pkg.sv
// Shared definitions for the adder tree datapath and its operand feeder.
//   - default width constants (also used by the adder tree modules)
//   - feeder FSM state encoding
//   - latency counter width (covers TREE_LATENCY 1..15)
package adder_tree_pkg;

  localparam int AT_ADDER_WIDTH  = 48;
  localparam int AT_NUM_OPS      = 8;
  localparam int AT_TREE_LATENCY = 2;
  localparam int AT_LAT_CTR_W    = 4;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HOLD   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/adder_tree_latency_ctr.sv
// Loadable down-counter with zero flag; times the adder tree latency.
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero       : counter value is zero
module adder_tree_latency_ctr
  import adder_tree_pkg::*;
#(
  parameter int CW = AT_LAT_CTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/adder_tree_feeder.sv
// Collects NUM_OPS operands from a valid/ready stream, presents them packed
// to an external adder tree with a one-cycle launch pulse, waits
// TREE_LATENCY cycles, captures the tree result and offers it on a
// valid/ready result port.
//   in_valid/in_ready/in_data   : operand stream (first word = operand 0)
//   isum                        : packed operands, operand k at [k*ADDER_WIDTH +: ADDER_WIDTH]
//   launch                      : one-cycle pulse, isum complete
//   tree_sum                    : tree result, sampled TREE_LATENCY cycles after launch
//   res_valid/res_ready/res_data: captured result handshake
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int ADDER_WIDTH  = AT_ADDER_WIDTH,
  parameter int NUM_OPS      = AT_NUM_OPS,
  parameter int TREE_LATENCY = AT_TREE_LATENCY,
  parameter int RES_W        = ADDER_WIDTH + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDER_WIDTH-1:0]         in_data,
  output logic [NUM_OPS*ADDER_WIDTH-1:0] isum,
  output logic                           launch,
  input  logic [RES_W-1:0]               tree_sum,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [RES_W-1:0]               res_data
);

  localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_OPS - 1);
  localparam logic [AT_LAT_CTR_W-1:0] LAT_LOAD = AT_LAT_CTR_W'(TREE_LATENCY - 1);

  feeder_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_OPS-1:0][ADDER_WIDTH-1:0] slot_q, slot_d;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic in_ready_q, in_ready_d;
  logic ctr_load, ctr_dec, ctr_zero;
  logic accept;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    res_data_d = res_data_q;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          slot_d[idx_q] = in_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_LAUNCH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        ctr_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (ctr_zero) begin
          res_data_d = tree_sum;
          state_d    = ST_HOLD;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (res_ready) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
    // Registered from the next state so ready stays low through reset and
    // rises on the first edge after it.
    in_ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      idx_q      <= '0;
      slot_q     <= '0;
      res_data_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      res_data_q <= res_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  adder_tree_latency_ctr #(.CW(AT_LAT_CTR_W)) u_lat_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ctr_load),
    .load_val (LAT_LOAD),
    .dec      (ctr_dec),
    .zero     (ctr_zero)
  );

  assign in_ready  = in_ready_q;
  assign isum      = slot_q;
  assign launch    = (state_q == ST_LAUNCH);
  assign res_valid = (state_q == ST_HOLD);
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_adder_tree_feeder.sv
module tb_adder_tree_feeder;

  localparam int W  = 48;
  localparam int N  = 8;
  localparam int TL = 2;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  // default build
  logic          in_valid = 0, in_ready, launch, res_valid, res_ready = 0;
  logic [W-1:0]  in_data = '0;
  logic [N*W-1:0] isum;
  logic [W:0]    tree_sum, res_data;

  // small build: 2 operands, latency 1
  logic          in_valid2 = 0, in_ready2, launch2, res_valid2, res_ready2 = 0;
  logic [15:0]   in_data2 = '0;
  logic [31:0]   isum2;
  logic [16:0]   tree_sum2, res_data2;

  // 2-level tree on operands 0..3, wrapping at result width
  assign tree_sum  = (W+1)'(isum[0*W +: W]) + (W+1)'(isum[1*W +: W])
                   + (W+1)'(isum[2*W +: W]) + (W+1)'(isum[3*W +: W]);
  assign tree_sum2 = 17'(isum2[15:0]) + 17'(isum2[31:16]);

  adder_tree_feeder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .isum(isum), .launch(launch), .tree_sum(tree_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  adder_tree_feeder #(.ADDER_WIDTH(16), .NUM_OPS(2), .TREE_LATENCY(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .isum(isum2), .launch(launch2), .tree_sum(tree_sum2),
    .res_valid(res_valid2), .res_ready(res_ready2), .res_data(res_data2)
  );

  int total = 0, bad = 0;
  int launch_cnt = 0, rv_cnt = 0;

  always @(negedge clk) begin
    launch_cnt <= launch_cnt + int'(launch);
    rv_cnt     <= rv_cnt + int'(res_valid);
  end

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0][W-1:0] w;
    bit                  gap;
    int                  hold;
    logic [W:0]          exp_sum;
  } vec_t;

  // At a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [W-1:0] w);
    int t = 0;
    in_valid = 1; in_data = w;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("send_timeout", 1, 0);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic fill(input logic [N-1:0][W-1:0] w, input bit gap);
    for (int k = 0; k < N; k++) begin
      send_word(w[k]);
      if (k < N-1) begin
        chk("no_early_launch", launch, 0);
        if (gap) begin
          @(negedge clk);
          chk("gap_no_launch", launch, 0);
        end
      end
    end
  endtask

  // Entered at the negedge where the feeder sits in LAUNCH.
  task automatic finish_batch(input logic [N-1:0][W-1:0] w, input logic [W:0] exp_sum,
                              input int hold, input int lc0);
    int k = 0;
    chk("launch_pulse", launch, 1);
    chk("ready_low_launch", in_ready, 0);
    chk("isum_at_launch", isum, w);
    res_ready = 0;
    in_valid = 1; in_data = 48'($urandom);
    while (!res_valid && k < 20) begin
      @(negedge clk); k++;
      chk("isum_stable", isum, w);
      chk("ready_low_wait", in_ready, 0);
      chk("launch_once", launch, 0);
      in_data = 48'($urandom);
    end
    chk("latency", k, TL + 1);
    chk("res_data", res_data, exp_sum);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_sum);
      chk("hold_ready_low", in_ready, 0);
      chk("hold_isum", isum, w);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0; in_valid = 0;
    chk("valid_drop", res_valid, 0);
    chk("ready_back", in_ready, 1);
    chk("isum_kept", isum, w);
    chk("launch_count", launch_cnt, lc0 + 1);
  endtask

  function automatic logic [W:0] model_sum(input logic [N-1:0][W-1:0] w);
    logic [W:0] s = '0;
    for (int k = 0; k < 4; k++) s = s + (W+1)'(w[k]);
    return s;
  endfunction

  initial begin
    vec_t tv[4];
    logic [N-1:0][W-1:0] w;
    int lc0, rv0, k;

    for (int i = 0; i < N; i++) begin
      tv[0].w[i] = 48'(i + 1);
      tv[1].w[i] = 48'hFFFF_FFFF_FFFF;
      tv[2].w[i] = 48'h1000_0000_0000 * 48'(i + 1);
      tv[3].w[i] = 48'hFFFF_FFFF_FFFF - 48'(i);
    end
    tv[0].gap = 0; tv[0].hold = 2;  tv[0].exp_sum = 49'd10;
    tv[1].gap = 1; tv[1].hold = 10; tv[1].exp_sum = 49'h3_FFFF_FFFF_FFFC;
    tv[2].gap = 0; tv[2].hold = 0;  tv[2].exp_sum = 49'h0_A000_0000_0000;
    tv[3].gap = 0; tv[3].hold = 0;  tv[3].exp_sum = 49'h3_FFFF_FFFF_FFF6;

    // reset values
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_launch", launch, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_isum", isum, 0);
    chk("rst_isum2", isum2, 0);
    @(negedge clk); rst_n = 1;
    chk("ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", in_ready, 1);

    // table-driven batches; res_ready held high during fill to show it is ignored
    for (int v = 0; v < 4; v++) begin
      lc0 = launch_cnt;
      res_ready = 1;
      fill(tv[v].w, tv[v].gap);
      chk("res_ready_ignored", res_valid, 0);
      finish_batch(tv[v].w, tv[v].exp_sum, tv[v].hold, lc0);
    end

    // randomized batches against the sum model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) w[i] = 48'({$urandom, $urandom});
      lc0 = launch_cnt;
      fill(w, 1'($urandom));
      finish_batch(w, model_sum(w), int'($urandom_range(0, 4)), lc0);
    end

    // reset during WAIT
    for (int i = 0; i < N; i++) w[i] = 48'($urandom);
    fill(w, 0);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("rstw_in_ready", in_ready, 0);
    chk("rstw_launch", launch, 0);
    chk("rstw_res_valid", res_valid, 0);
    chk("rstw_res_data", res_data, 0);
    chk("rstw_isum", isum, 0);
    @(negedge clk); rst_n = 1;
    rv0 = rv_cnt; lc0 = launch_cnt;
    repeat (8) @(negedge clk);
    chk("rstw_no_result", rv_cnt, rv0);
    chk("rstw_no_launch", launch_cnt, lc0);
    chk("rstw_ready", in_ready, 1);

    // reset after 5 operands: partial fill discarded
    for (int i = 0; i < 5; i++) send_word(48'hDEAD_0000_0000 + 48'(i));
    #1 rst_n = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rstf_isum", isum, 0);
    for (int i = 0; i < N; i++) w[i] = 48'(100 + i);
    lc0 = launch_cnt;
    for (int i = 0; i < N-1; i++) send_word(w[i]);
    chk("rstf_no_launch7", launch, 0);
    chk("rstf_ready7", in_ready, 1);
    send_word(w[N-1]);
    finish_batch(w, 49'd406, 1, lc0);

    // small build: 2 operands, latency 1
    chk("s_ready", in_ready2, 1);
    in_valid2 = 1; in_data2 = 16'hF00D;
    @(negedge clk);
    chk("s_no_launch1", launch2, 0);
    in_data2 = 16'hBEEF;
    @(negedge clk);
    in_valid2 = 0;
    chk("s_launch", launch2, 1);
    chk("s_isum", isum2, 32'hBEEF_F00D);
    chk("s_ready_low", in_ready2, 0);
    k = 0;
    while (!res_valid2 && k < 20) begin @(negedge clk); k++; end
    chk("s_latency", k, 2);
    chk("s_res_data", res_data2, 17'h1_AEFC);
    res_ready2 = 1;
    @(negedge clk);
    res_ready2 = 0;
    chk("s_valid_drop", res_valid2, 0);
    chk("s_ready_back", in_ready2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/adder_tree_feeder.md
ADDER_TREE_FEEDER -- requirements
Module: adder_tree_feeder

Interface
REQ-001 Parameter ADDER_WIDTH, default 48, operand width in bits.
REQ-002 Parameter NUM_OPS, default 8, operands per launch; SHALL be a power of two, 2..8.
REQ-003 Parameter TREE_LATENCY, default 2, cycles from launch to valid tree result; legal range 1..15.
REQ-004 Parameter RES_W, default ADDER_WIDTH+1, width of the tree result captured.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  operand stream valid.
REQ-008 in_ready  out  1  operand stream ready.
REQ-009 in_data  in  ADDER_WIDTH  operand word; first accepted word is operand 0.
REQ-010 isum  out  NUM_OPS*ADDER_WIDTH  packed operands to tree; operand k at bits [k*ADDER_WIDTH +: ADDER_WIDTH].
REQ-011 launch  out  1  one-cycle pulse; isum is stable and complete.
REQ-012 tree_sum  in  RES_W  tree result, sampled TREE_LATENCY cycles after launch.
REQ-013 res_valid  out  1  result handshake valid.
REQ-014 res_ready  in  1  result handshake ready.
REQ-015 res_data  out  RES_W  captured tree result.

Function
REQ-016 FSM states FILL, LAUNCH, WAIT, HOLD; reset state FILL.
REQ-017 FILL: in_ready=1; each cycle with in_valid&in_ready writes in_data to operand slot idx and increments idx.
REQ-018 FILL -> LAUNCH on the acceptance that fills slot NUM_OPS-1; idx wraps to 0 on that same edge.
REQ-019 LAUNCH: launch=1 for exactly one cycle, in_ready=0; next state WAIT, latency counter loaded with TREE_LATENCY-1.
REQ-020 WAIT: counter decrements per cycle; on the cycle counter=0 tree_sum is registered into res_data, state -> HOLD.
REQ-021 Launch-to-res_valid latency SHALL be exactly TREE_LATENCY+1 cycles (launch at cycle t, res_valid high from t+TREE_LATENCY+1).
REQ-022 HOLD: res_valid=1, res_data stable until res_valid&res_ready; then -> FILL with in_ready=1 next cycle.
REQ-023 in_ready SHALL be 0 in LAUNCH, WAIT, HOLD; operands accepted only in FILL, no skid buffer.
REQ-024 isum SHALL hold the last launched operand set throughout WAIT and HOLD; slots overwrite only during the next FILL.
REQ-025 in_valid gaps in FILL SHALL stall idx without corrupting stored slots.
REQ-026 res_data SHALL be tree_sum unmodified (no truncation/extension) when RES_W equals tree output width.
REQ-027 res_ready asserted while res_valid=0 SHALL be ignored.

Reset
REQ-028 rst_n low asynchronously forces: state FILL, idx 0, counter 0, launch 0, res_valid 0, in_ready 0 during reset, res_data 0, all isum slots 0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 Reset mid-FILL, mid-WAIT or in HOLD SHALL discard partial operands and pending result; no launch or res_valid follows reset without a fresh full fill.

Structure
REQ-031 Shared package adder_tree_pkg holds the FSM state enum and default width constants (ADDER_WIDTH 48, NUM_OPS 8, TREE_LATENCY 2); the existing adder tree modules use the same width constant.
REQ-032 One sub-module natural: adder_tree_latency_ctr (loadable down-counter, zero flag); operand bank and FSM stay in the top.

Verification
REQ-033 Reset then stream 1..8 with in_valid held high -> in_ready low after 8th accept, one launch pulse, isum slots 0..7 = 1..8, res_valid at launch+3 with res_data = driven tree_sum.
REQ-034 Gap stimulus: in_valid toggled every other cycle with 8 words 0xFFFF_FFFF_FFFF -> launch after 8th accept only, all slots 0xFFFF_FFFF_FFFF; with real 2-level tree attached (sum of slots 0..3) res_data = 0x3_FFFF_FFFF_FFFC.
REQ-035 Backpressure: res_ready low 10 cycles in HOLD -> res_valid and res_data stable, in_ready 0, in_valid ignored; res_ready high -> FILL next cycle.
REQ-036 Back-to-back: two 8-word batches, res_ready tied high -> two launches, second batch first accept exactly 1 cycle after first result handshake.
REQ-037 rst_n pulsed low during WAIT (after 5 operands of next batch not yet sent) -> res_valid never asserts, all outputs 0, next launch requires 8 new accepts.
REQ-038 TREE_LATENCY=1 and NUM_OPS=2 build -> launch after 2 accepts, res_valid at launch+2.
